// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with tree-PLRU replacement.
// Hits complete in the request cycle. A miss fetches one 256-bit line and then
// replays the request as a hit. A flush that arrives during a fill is deferred
// until the fill has been written.
module icache_assoc #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned num_ways = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    input  logic         flush,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned S_TAG    = 32 - s_offset - s_index;
    localparam int unsigned NUM_SETS = 2 ** s_index;
    localparam int unsigned WAY_W    = $clog2(num_ways);
    localparam int unsigned PLRU_W   = num_ways - 1;
    localparam int unsigned LINE_W   = 256;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSHWAIT
    } state_e;

    state_e              state_q;
    logic [num_ways-1:0] valid_q [NUM_SETS];
    logic [PLRU_W-1:0]   plru_q  [NUM_SETS];
    logic [S_TAG-1:0]    tag_q   [NUM_SETS][num_ways];
    logic [LINE_W-1:0]   data_q  [NUM_SETS][num_ways];
    logic [WAY_W-1:0]    victim_q;
    logic                flush_pend_q;

    logic [s_index-1:0]  idx;
    logic [S_TAG-1:0]    tag;
    logic [num_ways-1:0] hit_vec;
    logic                hit_any;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim;
    logic [LINE_W-1:0]   hit_line;
    logic                fill_done;
    logic                unused_addr_bits;

    // Walk the PLRU tree: bit 0 steers toward the lower half, bit 1 toward the upper half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int unsigned node;
        node = 1;
        for (int l = 0; l < int'(WAY_W); l++) begin
            node = 2 * node + 32'(bits[node-1]);
        end
        return WAY_W'(node - num_ways);
    endfunction

    // Point every node on the path to the accessed way in the opposite direction.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] r;
        int unsigned       node;
        logic              dir;
        r    = bits;
        node = 1;
        for (int l = 0; l < int'(WAY_W); l++) begin
            dir       = way[WAY_W-1-l];
            r[node-1] = ~dir;
            node      = 2 * node + 32'(dir);
        end
        return r;
    endfunction

    assign idx              = mem_address[s_offset +: s_index];
    assign tag              = mem_address[31 -: S_TAG];
    assign unused_addr_bits = ^mem_address[1:0];
    assign fill_done        = (state_q == FETCH) && pmem_resp;

    // Tag compare across the indexed set. The lowest matching way is selected.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < int'(num_ways); w++) begin
            hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
        end
        for (int w = int'(num_ways) - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
        hit_any = |hit_vec;
    end

    // Victim choice: the lowest invalid way if there is one, otherwise the PLRU way.
    always_comb begin
        victim = plru_victim(plru_q[idx]);
        for (int w = int'(num_ways) - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    // CPU-side response. It is gated by flush, so a flush in the same cycle beats the hit.
    always_comb begin
        hit_line  = data_q[idx][hit_way];
        mem_rdata = hit_line[{mem_address[4:2], 5'b00000} +: 32];
        mem_resp  = !rst && (state_q == IDLE) && mem_read && !flush && hit_any;
    end

    // Memory-side fill request. It reuses the held CPU address, aligned to the line.
    always_comb begin
        pmem_read    = (state_q == FETCH);
        pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
    end

    // Controller state, valid/PLRU metadata, victim latch and deferred flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            flush_pend_q <= 1'b0;
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < int'(NUM_SETS); s++) begin
                            valid_q[s] <= '0;
                            plru_q[s]  <= '0;
                        end
                    end else if (mem_read) begin
                        if (hit_any) begin
                            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                        end else begin
                            victim_q <= victim;
                            state_q  <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (pmem_resp) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        state_q <= (flush_pend_q || flush) ? FLUSHWAIT : IDLE;
                    end
                end
                FLUSHWAIT: begin
                    for (int s = 0; s < int'(NUM_SETS); s++) begin
                        valid_q[s] <= '0;
                        plru_q[s]  <= '0;
                    end
                    flush_pend_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line and tag storage. It has no reset and is only written when a fill completes.
    always_ff @(posedge clk) begin
        if (!rst && fill_done) begin
            data_q[idx][victim_q] <= pmem_rdata;
            tag_q[idx][victim_q]  <= tag;
        end
    end

endmodule
